run_sequencer: RTL and testbench

Host-side run controller for the 9-bit-instruction CPU top level. It drives the core's `start` input and watches its `halt` output, which makes it the initiating end of that interface. One run goes: preload operand bytes into data memory through a backdoor port, pulse the core into reset and release it, count cycles until `halt`, then stream result bytes back out of data memory. It sits between the testbench or host stream and the core, and owns the data-memory port whenever it is not in RUN.

---
 rtl/run_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_run_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Host-side run controller: preload data memory, pulse the core's start,
// time the run until halt, then stream results back out. Optional watchdog: RUN_SEQ_WATCHDOG_EN.
module run_sequencer #(
   parameter int unsigned LOAD_BASE    = 0,
   parameter int unsigned LOAD_N       = 8,
   parameter int unsigned DUMP_BASE    = 128,
   parameter int unsigned DUMP_N       = 8,
   parameter int unsigned START_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [7:0]  ld_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [7:0]  rd_data,
   output logic        cpu_start,
   input  logic        cpu_halt,
   output logic [7:0]  mem_addr,
   output logic        mem_wr,
   output logic        mem_rd,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [31:0] run_cycles
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_DUMP  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ld_cnt_q, ld_cnt_d;
   logic [31:0] dp_cnt_q, dp_cnt_d;
   logic [31:0] st_cnt_q, st_cnt_d;
   logic [31:0] run_cycles_q, run_cycles_d;
   logic        timeout_q, timeout_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ld_ready_q, ld_ready_d;
   logic        rd_valid_q, rd_valid_d;
   logic        cpu_start_q, cpu_start_d;
   logic        mem_rd_q, mem_rd_d;

   logic [31:0] ld_addr_full;
   logic [31:0] dp_addr_full;
   logic        ld_hs;
   logic        rd_hs;

   assign ld_addr_full = LOAD_BASE + ld_cnt_q;
   assign dp_addr_full = DUMP_BASE + dp_cnt_q;
   assign ld_hs        = ld_ready_q & ld_valid;
   assign rd_hs        = rd_valid_q & rd_ready;

   always_comb begin
      state_d      = state_q;
      ld_cnt_d     = ld_cnt_q;
      dp_cnt_d     = dp_cnt_q;
      st_cnt_d     = st_cnt_q;
      run_cycles_d = run_cycles_q;
      timeout_d    = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               ld_cnt_d = 32'd0;
               dp_cnt_d = 32'd0;
               state_d  = (LOAD_N == 0) ? S_START : S_LOAD;
            end
         end
         S_LOAD: begin
            if (ld_hs) begin
               if (ld_cnt_q == LOAD_N - 1) begin
                  state_d = S_START;
               end else begin
                  ld_cnt_d = ld_cnt_q + 32'd1;
               end
            end
         end
         S_START: begin
            if (st_cnt_q == START_CYCLES - 1) begin
               state_d = S_RUN;
            end else begin
               st_cnt_d = st_cnt_q + 32'd1;
            end
         end
         S_RUN: begin
            run_cycles_d = (run_cycles_q == 32'hFFFF_FFFF) ? run_cycles_q
                                                          : run_cycles_q + 32'd1;
            // run_cycles_q is zero only on the first RUN cycle, where halt may be stale
            if (cpu_halt && (run_cycles_q != 32'd0)) begin
               dp_cnt_d = 32'd0;
               state_d  = (DUMP_N == 0) ? S_DONE : S_DUMP;
            end
`ifdef RUN_SEQ_WATCHDOG_EN
            else if (run_cycles_d == TIMEOUT) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
`endif
         end
         S_DUMP: begin
            if (rd_hs) begin
               if (dp_cnt_q == DUMP_N - 1) begin
                  state_d = S_DONE;
               end else begin
                  dp_cnt_d = dp_cnt_q + 32'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Entering START begins a fresh run measurement
      if ((state_d == S_START) && (state_q != S_START)) begin
         st_cnt_d     = 32'd0;
         run_cycles_d = 32'd0;
         timeout_d    = 1'b0;
      end

      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      ld_ready_d  = (state_d == S_LOAD);
      rd_valid_d  = (state_d == S_DUMP);
      mem_rd_d    = (state_d == S_DUMP);
      cpu_start_d = (state_d == S_START);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ld_cnt_q     <= 32'd0;
         dp_cnt_q     <= 32'd0;
         st_cnt_q     <= 32'd0;
         run_cycles_q <= 32'd0;
         timeout_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ld_ready_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         cpu_start_q  <= 1'b0;
         mem_rd_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ld_cnt_q     <= ld_cnt_d;
         dp_cnt_q     <= dp_cnt_d;
         st_cnt_q     <= st_cnt_d;
         run_cycles_q <= run_cycles_d;
         timeout_q    <= timeout_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ld_ready_q   <= ld_ready_d;
         rd_valid_q   <= rd_valid_d;
         cpu_start_q  <= cpu_start_d;
         mem_rd_q     <= mem_rd_d;
      end
   end

`ifdef RUN_SEQ_WATCHDOG_EN
   assign timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT == 0) | timeout_q;
   assign timeout = 1'b0;
`endif

   assign busy       = busy_q;
   assign done       = done_q;
   assign ld_ready   = ld_ready_q;
   assign rd_valid   = rd_valid_q;
   assign cpu_start  = cpu_start_q;
   assign mem_rd     = mem_rd_q;
   assign mem_wr     = ld_hs;
   assign mem_wdata  = ld_data;
   assign mem_addr   = rd_valid_q ? dp_addr_full[7:0] : ld_addr_full[7:0];
   assign rd_data    = mem_rdata;
   assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: memory and core models, dump bytes checked in order.
module tb_run_sequencer;

   localparam int unsigned HALT_AT = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        go = 1'b0;
   logic        busy, done, timeout;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [7:0]  ld_data = 8'h00;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [7:0]  rd_data;
   logic        cpu_start;
   logic        cpu_halt;
   logic [7:0]  mem_addr;
   logic        mem_wr, mem_rd;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [31:0] run_cycles;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0]  mem [256];
   logic        mem_init = 1'b1;
   logic        halt_en = 1'b1;
   logic [7:0]  result = 8'h00;
   logic [31:0] core_cnt = 32'd0;
   logic        core_armed = 1'b0;
   logic        core_wr;

   logic [7:0]  sb_q [$];
   int          start_hi_cnt = 0;
   int          done_cnt = 0;
   logic        stall_prev = 1'b0;
   logic [7:0]  stall_data = 8'h00;
   logic [7:0]  stall_addr = 8'h00;

   run_sequencer #(
      .LOAD_BASE(0), .LOAD_N(4), .DUMP_BASE(255), .DUMP_N(3),
      .START_CYCLES(2), .TIMEOUT(50)
   ) dut (
      .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done), .timeout(timeout),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .cpu_start(cpu_start), .cpu_halt(cpu_halt),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Core model: stale halt on the first RUN cycle, real halt on RUN cycle HALT_AT,
   // and one result byte written to address 255 mid-run.
   always @(posedge clk) begin
      if (cpu_start) begin
         core_cnt   <= 32'd0;
         core_armed <= 1'b1;
      end else if (core_armed) begin
         core_cnt <= core_cnt + 32'd1;
      end
   end
   assign cpu_halt = core_armed && !cpu_start &&
                     ((core_cnt == 32'd0) || (halt_en && core_cnt == HALT_AT - 1));
   assign core_wr  = core_armed && !cpu_start && busy && (core_cnt == 32'd5);

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      end else if (mem_wr) begin
         mem[mem_addr] <= mem_wdata;
      end else if (core_wr) begin
         mem[8'd255] <= result;
      end
   end
   assign mem_rdata = mem[mem_addr];

   always @(negedge clk) begin
      logic [7:0] exp_b;
      if (cpu_start) start_hi_cnt++;
      if (done) done_cnt++;
      if (rd_valid && !rd_ready) begin
         if (stall_prev) begin
            chk("stall_data", {24'd0, rd_data}, {24'd0, stall_data});
            chk("stall_addr", {24'd0, mem_addr}, {24'd0, stall_addr});
         end
         stall_prev = 1'b1;
         stall_data = rd_data;
         stall_addr = mem_addr;
      end else begin
         stall_prev = 1'b0;
      end
      if (rd_valid && rd_ready) begin
         if (sb_q.size() != 0) exp_b = sb_q.pop_front();
         else exp_b = ~rd_data;
         chk("dump_byte", {24'd0, rd_data}, {24'd0, exp_b});
         chk("dump_mem_rd", {31'd0, mem_rd}, 32'd1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got=expired expected=finish");
      $fatal(1, "time limit");
   end

   initial begin
      logic [7:0] vals [4];
      int start_base, done_base, w, got_b;
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

      tick(); tick();
      reset = 1'b0; mem_init = 1'b0;
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("rst_run_cycles", run_cycles, 32'd0);

      // Reset in the middle of a load after 3 of 4 bytes
      go = 1'b1; tick(); go = 1'b0;
      chk("load_ready", {31'd0, ld_ready}, 32'd1);
      for (int b = 0; b < 3; b++) begin
         ld_valid = 1'b1; ld_data = 8'hA1 + 8'(b);
         tick();
      end
      ld_valid = 1'b0; reset = 1'b1;
      tick();
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);
      chk("midrst_cpu_start", {31'd0, cpu_start}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      tick();
      for (int b = 0; b < 3; b++) chk("midrst_mem_written", {24'd0, mem[b]}, {24'd0, 8'hA1 + 8'(b)});
      chk("midrst_mem_untouched", {24'd0, mem[3]}, {24'd0, 8'h03 ^ 8'h5A});
      chk("idle_stays", {31'd0, busy}, 32'd0);

      // Full run: gapped load, stale halt, go during RUN, stalled dump with wrap
      result = 8'hC7;
      halt_en = 1'b1;
      sb_q.push_back(result);
      start_base = start_hi_cnt;
      done_base = done_cnt;
      go = 1'b1; tick(); go = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1; ld_data = vals[i];
         if (i < 2) sb_q.push_back(vals[i]);
         tick();
         ld_valid = 1'b0;
         tick();
      end
      for (int i = 0; i < 4; i++) chk("load_mem", {24'd0, mem[i]}, {24'd0, vals[i]});
      w = 0;
      while (!cpu_start && w < 20) begin tick(); w++; end
      while (cpu_start && w < 20) begin tick(); w++; end
      chk("reach_run", {31'd0, busy && !cpu_start && !ld_ready && !rd_valid}, 32'd1);
      go = 1'b1; tick(); go = 1'b0;
      w = 0;
      while (!rd_valid && w < 100) begin tick(); w++; end
      chk("wait_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("run_cycles_b", run_cycles, HALT_AT);
      for (int i = 0; i < 3; i++) tick();
      rd_ready = 1'b1;
      w = 0;
      while (!done && w < 20) begin tick(); w++; end
      rd_ready = 1'b0;
      chk("wait_done", {31'd0, done}, 32'd1);
      chk("run_cycles_held", run_cycles, HALT_AT);
      for (int i = 0; i < 5; i++) tick();
      chk("start_pulse_len", start_hi_cnt - start_base, 32'd2);
      chk("done_once", done_cnt - done_base, 32'd1);
      chk("idle_after_run", {31'd0, busy}, 32'd0);
      chk("sb_drained", sb_q.size(), 32'd0);
      got_b = run_cycles;
      chk("run_cycles_hold_idle", got_b, HALT_AT);

      // No halt: watchdog fires, or without it the sequencer keeps waiting
      halt_en = 1'b0;
      done_base = done_cnt;
      go = 1'b1; tick(); go = 1'b0;
      ld_valid = 1'b1;
      w = 0;
      while (!cpu_start && w < 20) begin tick(); w++; end
      ld_valid = 1'b0;
      while (cpu_start && w < 40) begin tick(); w++; end
      chk("nohalt_reach_run", {31'd0, busy && !cpu_start}, 32'd1);
`ifdef RUN_SEQ_WATCHDOG_EN
      w = 0;
      while (!done && w < 200) begin
         chk("wd_no_rd_valid", {31'd0, rd_valid}, 32'd0);
         tick(); w++;
      end
      chk("wd_done", {31'd0, done}, 32'd1);
      chk("wd_timeout", {31'd0, timeout}, 32'd1);
      chk("wd_run_cycles", run_cycles, 32'd50);
      tick();
      chk("wd_timeout_sticky", {31'd0, timeout}, 32'd1);
      chk("wd_done_once", done_cnt - done_base, 32'd1);
`else
      for (int i = 0; i < 999; i++) tick();
      chk("nowd_busy", {31'd0, busy}, 32'd1);
      chk("nowd_run_cycles", run_cycles, 32'd999);
      chk("nowd_timeout", {31'd0, timeout}, 32'd0);
      chk("nowd_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("nowd_no_done", done_cnt - done_base, 32'd0);
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("final_rst_busy", {31'd0, busy}, 32'd0);
      chk("final_rst_cpu_start", {31'd0, cpu_start}, 32'd0);
      chk("final_rst_run_cycles", run_cycles, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
